// File: rtl/mem_wb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_pkg
//   Shared constants for the MEM->WB pipeline stage: default widths, the
//   "no register" writeback address, the all-zero data word and a helper
//   that computes the width of the packed stage payload.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package mem_wb_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CP0_ADDR_W = 5;

    // Register 0 is hard-wired zero, so it doubles as "no writeback".
    localparam logic [ADDR_W_DEF-1:0] NOP_REG_ADDR = '0;
    localparam logic [DATA_W_DEF-1:0] ZERO_WORD    = '0;

    // Packed payload layout, MSB first:
    //   wreg[LANES] wd[LANES*ADDR_W] wdata[LANES*DATA_W] whilo hi lo
    //   llbit_we llbit_val cp0_we cp0_addr cp0_data
    function automatic int PAYLOAD_W(input int lanes, input int data_w, input int addr_w);
        return lanes * (1 + addr_w + data_w)
             + 1 + 2 * data_w
             + 2
             + 1 + CP0_ADDR_W + data_w;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_skid_reg
//   Generic valid/ready pipeline register with a one-entry skid buffer.
//   Gives full throughput under back-pressure while in_ready comes straight
//   from a flop, so there is no combinational path from out_ready to in_ready.
//   Ports:
//     clk, rst (sync, active-low), flush (drop everything held)
//     in_valid / in_ready / in_data    upstream handshake and payload
//     out_valid / out_ready / out_data downstream handshake and payload
//   Parameters: W payload width, CLEAR value loaded on reset/flush/bubble.
// ---------------------------------------------------------------------------
module mem_wb_pipe_skid_reg #(
    parameter int           W     = 8,
    parameter logic [W-1:0] CLEAR = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         skid_valid_q;
    logic [W-1:0] skid_data_q;

    logic accept;
    logic out_free;

    // Upstream may only send while the skid slot is empty; that keeps the
    // ready signal a pure flop output.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid_q | out_ready;

    // The output register reloads whenever it is free: the skid entry has
    // priority (it is older), otherwise a new entry, otherwise a cleared
    // bubble so no stale enable remains visible. A stalled output parks the
    // incoming entry in the skid slot.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= CLEAR;
            skid_valid_q <= 1'b0;
            skid_data_q  <= CLEAR;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
                skid_data_q  <= CLEAR;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data;
            end else begin
                out_valid_q <= 1'b0;
                out_data_q  <= CLEAR;
            end
        end else if (accept) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
//   MEM->WB pipeline stage carrying LANES register writebacks plus the shared
//   HI/LO, LLbit and CP0 writes, with valid/ready flow control and a skid
//   buffer. Also counts entries retired at WB.
//   Ports:
//     clk, rst (sync, active-low), flush
//     in_valid, in_ready, in_wreg, in_wd, in_wdata, in_whilo, in_hi, in_lo,
//     in_llbit_we, in_llbit_val, in_cp0_we, in_cp0_addr, in_cp0_data
//     out_valid, out_ready, wb_* (registered copies of in_*)
//     retire_cnt  entries consumed at WB, wraps silently
//   Lane k of wd/wdata sits at [k*W +: W]; lane 0 is the older instruction.
//   Same-address lanes are passed through untouched for the regfile.
// ---------------------------------------------------------------------------
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_wreg,
    input  logic [LANES*ADDR_W-1:0]   in_wd,
    input  logic [LANES*DATA_W-1:0]   in_wdata,
    input  logic                      in_whilo,
    input  logic [DATA_W-1:0]         in_hi,
    input  logic [DATA_W-1:0]         in_lo,
    input  logic                      in_llbit_we,
    input  logic                      in_llbit_val,
    input  logic                      in_cp0_we,
    input  logic [CP0_ADDR_W-1:0]     in_cp0_addr,
    input  logic [DATA_W-1:0]         in_cp0_data,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          wb_wreg,
    output logic [LANES*ADDR_W-1:0]   wb_wd,
    output logic [LANES*DATA_W-1:0]   wb_wdata,
    output logic                      wb_whilo,
    output logic [DATA_W-1:0]         wb_hi,
    output logic [DATA_W-1:0]         wb_lo,
    output logic                      wb_llbit_we,
    output logic                      wb_llbit_val,
    output logic                      wb_cp0_we,
    output logic [CP0_ADDR_W-1:0]     wb_cp0_addr,
    output logic [DATA_W-1:0]         wb_cp0_data,

    output logic [CNT_W-1:0]          retire_cnt
);

    localparam int PW = PAYLOAD_W(LANES, DATA_W, ADDR_W);

    // Cleared payload: every enable low, addresses at the no-op register,
    // data zero.
    localparam logic [PW-1:0] CLEAR_PAYLOAD = {
        {LANES{1'b0}},
        {LANES{ADDR_W'(NOP_REG_ADDR)}},
        {LANES{DATA_W'(ZERO_WORD)}},
        1'b0, DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD),
        1'b0, 1'b0,
        1'b0, {CP0_ADDR_W{1'b0}}, DATA_W'(ZERO_WORD)
    };

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;
    logic [CNT_W-1:0] retire_cnt_q;

    assign in_payload = {
        in_wreg, in_wd, in_wdata,
        in_whilo, in_hi, in_lo,
        in_llbit_we, in_llbit_val,
        in_cp0_we, in_cp0_addr, in_cp0_data
    };

    mem_wb_pipe_skid_reg #(
        .W     (PW),
        .CLEAR (CLEAR_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {
        wb_wreg, wb_wd, wb_wdata,
        wb_whilo, wb_hi, wb_lo,
        wb_llbit_we, wb_llbit_val,
        wb_cp0_we, wb_cp0_addr, wb_cp0_data
    } = out_payload;

    // A drain on the flush cycle still really happened at WB, so the
    // counter ignores flush and only honours reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule
